// File: rtl/fpga_config_loader_if.sv
// rtl/fpga_config_loader_if.sv - byte-serial bitstream handshake into the config loader
interface fpga_config_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - frames a byte-serial bitstream, verifies its checksum and
// commits the shadow register atomically onto the fabric select buses
module fpga_config_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         BRB_W     = 900,
  parameter int         BSB_W     = 1728,
  parameter int         LB_W      = 80,
  parameter int         IO_W      = 20
) (
  input  logic                clk,
  input  logic                rst,
  fpga_config_loader_if.slave cfg_in,
  output logic [BRB_W-1:0]    brbselect,
  output logic [BSB_W-1:0]    bsbselect,
  output logic [LB_W-1:0]     lbselect,
  output logic [IO_W-1:0]     leftioselect,
  output logic [IO_W-1:0]     rightioselect,
  output logic [IO_W-1:0]     topioselect,
  output logic [IO_W-1:0]     bottomioselect,
  output logic                fabric_rst,
  output logic                busy,
  output logic                cfg_done,
  output logic                cfg_error
);

  localparam int CFG_BITS = BRB_W + BSB_W + LB_W + 4 * IO_W;
  localparam int NBYTES   = (CFG_BITS + 7) / 8;
  localparam int SH_W     = NBYTES * 8;

  localparam int BSB_LO = BRB_W;
  localparam int LB_LO  = BSB_LO + BSB_W;
  localparam int LIO_LO = LB_LO + LB_W;
  localparam int RIO_LO = LIO_LO + IO_W;
  localparam int TIO_LO = RIO_LO + IO_W;
  localparam int BIO_LO = TIO_LO + IO_W;

  localparam logic [8:0] LAST_IDX = 9'(NBYTES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CSUM  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]      state;
  logic [SH_W-1:0] shadow;
  logic [8:0]      byte_cnt;
  logic [7:0]      csum_acc;
  logic [7:0]      rx_csum;
  logic            xfer;

  assign cfg_in.in_ready = (state != CHECK);
  assign xfer            = cfg_in.in_valid && cfg_in.in_ready;
  assign busy            = (state == LOAD) || (state == CSUM) || (state == CHECK);

  // Pad bits above CFG_BITS only exist to keep the shadow byte aligned.
  generate
    if (SH_W > CFG_BITS) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^shadow[SH_W-1:CFG_BITS];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      shadow         <= '0;
      byte_cnt       <= '0;
      csum_acc       <= '0;
      rx_csum        <= '0;
      brbselect      <= '0;
      bsbselect      <= '0;
      lbselect       <= '0;
      leftioselect   <= '0;
      rightioselect  <= '0;
      topioselect    <= '0;
      bottomioselect <= '0;
      fabric_rst     <= 1'b1;
      cfg_done       <= 1'b0;
      cfg_error      <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (xfer && cfg_in.in_data == SYNC_BYTE) begin
            state    <= LOAD;
            byte_cnt <= '0;
            csum_acc <= '0;
          end
        end
        LOAD: begin
          // SYNC_BYTE values here are payload, never a resync.
          if (xfer) begin
            shadow   <= {cfg_in.in_data, shadow[SH_W-1:8]};
            csum_acc <= csum_acc + cfg_in.in_data;
            if (byte_cnt == LAST_IDX) begin
              state <= CSUM;
            end else begin
              byte_cnt <= byte_cnt + 9'd1;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            rx_csum <= cfg_in.in_data;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (csum_acc == rx_csum) begin
            brbselect      <= shadow[BRB_W-1:0];
            bsbselect      <= shadow[BSB_LO +: BSB_W];
            lbselect       <= shadow[LB_LO +: LB_W];
            leftioselect   <= shadow[LIO_LO +: IO_W];
            rightioselect  <= shadow[RIO_LO +: IO_W];
            topioselect    <= shadow[TIO_LO +: IO_W];
            bottomioselect <= shadow[BIO_LO +: IO_W];
            fabric_rst     <= 1'b0;
            cfg_done       <= 1'b1;
            cfg_error      <= 1'b0;
            state          <= DONE;
          end else begin
            cfg_error <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// tb/tb_fpga_config_loader.sv - directed bench for the config loader: table of frames
// plus hand sequences for stalls, in-payload sync bytes and mid-frame reset
module tb_fpga_config_loader;

  localparam int NB  = 349;
  localparam int CFG = 2788;

  typedef struct {
    string      name;
    int         npre;
    logic [23:0] pre;
    logic [7:0] fill;
    logic [7:0] csum;
    bit         ok;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [899:0]  brbselect;
  logic [1727:0] bsbselect;
  logic [79:0]   lbselect;
  logic [19:0]   leftioselect, rightioselect, topioselect, bottomioselect;
  logic          fabric_rst, busy, cfg_done, cfg_error;

  fpga_config_loader_if bus ();

  fpga_config_loader dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_in         (bus),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect),
    .fabric_rst     (fabric_rst),
    .busy           (busy),
    .cfg_done       (cfg_done),
    .cfg_error      (cfg_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]     pay [NB];
  logic [CFG-1:0] exp_active = '0;
  bit             committed  = 1'b0;
  vec_t           vecs [4];

  function automatic vec_t mk(input string n, input int np, input logic [23:0] p,
                              input logic [7:0] f, input logic [7:0] c, input bit ok);
    vec_t v;
    v.name = n; v.npre = np; v.pre = p; v.fill = f; v.csum = c; v.ok = ok;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [2047:0] act, input logic [2047:0] req);
    int first;
    total++;
    if (act !== req) begin
      bad++;
      first = -1;
      for (int i = 2047; i >= 0; i--) if (act[i] !== req[i]) first = i;
      $display("FAIL %s: first differing bit %0d actual=%b required=%b",
               nm, first, act[first], req[first]);
    end
  endtask

  task automatic chk_sel(input string tag);
    chk_wide({tag, "/brb"},    2048'(brbselect),      2048'(exp_active[899:0]));
    chk_wide({tag, "/bsb"},    2048'(bsbselect),      2048'(exp_active[2627:900]));
    chk_wide({tag, "/lb"},     2048'(lbselect),       2048'(exp_active[2707:2628]));
    chk_wide({tag, "/left"},   2048'(leftioselect),   2048'(exp_active[2727:2708]));
    chk_wide({tag, "/right"},  2048'(rightioselect),  2048'(exp_active[2747:2728]));
    chk_wide({tag, "/top"},    2048'(topioselect),    2048'(exp_active[2767:2748]));
    chk_wide({tag, "/bottom"}, 2048'(bottomioselect), 2048'(exp_active[2787:2768]));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_byte: in_ready actual=0 required=1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_active = '0;
    committed  = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "/in_ready"},   32'(bus.in_ready), 32'd1);
    chk({tag, "/busy"},       32'(busy),         32'd0);
    chk({tag, "/cfg_done"},   32'(cfg_done),     32'd0);
    chk({tag, "/cfg_error"},  32'(cfg_error),    32'd0);
    chk({tag, "/fabric_rst"}, 32'(fabric_rst),   32'd1);
    chk_sel(tag);
  endtask

  // Sends SYNC + pay[] + csum, optionally stalling 10 cycles before byte gap_at.
  task automatic run_frame(input string nm, input int gap_at, input logic [7:0] csum, input bit ok);
    logic [2791:0] sh;
    send_byte(8'hA5);
    chk({nm, "/busy_load"}, 32'(busy), 32'd1);
    for (int k = 0; k < NB; k++) begin
      if (k == gap_at) begin
        repeat (10) begin
          @(posedge clk);
          #1;
        end
        chk({nm, "/busy_gap"},  32'(busy),         32'd1);
        chk({nm, "/ready_gap"}, 32'(bus.in_ready), 32'd1);
        chk_sel({nm, "/hold_gap"});
      end
      if (k == NB / 2) chk_sel({nm, "/hold_mid"});
      send_byte(pay[k]);
    end
    send_byte(csum);
    chk({nm, "/ready_check"}, 32'(bus.in_ready), 32'd0);
    chk({nm, "/busy_check"},  32'(busy),         32'd1);
    chk({nm, "/done_early"},  32'(cfg_done),     32'd0);
    chk_sel({nm, "/hold_check"});
    @(posedge clk);
    #1;
    if (ok) begin
      for (int k = 0; k < NB; k++) sh[8*k +: 8] = pay[k];
      exp_active = sh[CFG-1:0];
      committed  = 1'b1;
    end
    chk({nm, "/cfg_done"},   32'(cfg_done),   32'(ok));
    chk({nm, "/cfg_error"},  32'(cfg_error),  32'(!ok));
    chk({nm, "/fabric_rst"}, 32'(fabric_rst), 32'(!committed));
    chk({nm, "/busy_after"}, 32'(busy),       32'd0);
    chk({nm, "/ready_after"}, 32'(bus.in_ready), 32'd1);
    chk_sel({nm, "/commit"});
    @(posedge clk);
    #1;
    chk({nm, "/done_pulse_end"}, 32'(cfg_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk("bad_csum_01",       0, 24'h000000, 8'h01, 8'h5E, 1'b0);
    vecs[1] = mk("good_01",           1, 24'h000000, 8'h01, 8'h5D, 1'b1);
    vecs[2] = mk("bad_after_good_00", 0, 24'h000000, 8'h00, 8'h01, 1'b0);
    vecs[3] = mk("presync_ff",        3, 24'hFF3C00, 8'hFF, 8'hA3, 1'b1);

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    do_reset();
    chk_reset_state("reset");

    for (int v = 0; v < 4; v++) begin
      for (int p = 0; p < vecs[v].npre; p++) begin
        send_byte(vecs[v].pre[8*p +: 8]);
        chk({vecs[v].name, "/pre_discard_busy"}, 32'(busy), 32'd0);
      end
      for (int k = 0; k < NB; k++) pay[k] = vecs[v].fill;
      run_frame(vecs[v].name, -1, vecs[v].csum, vecs[v].ok);
      if (v == 1) begin
        chk("good_01/bottom_const", 32'(bottomioselect), 32'h10101);
        chk("good_01/brb_low",      32'(brbselect[31:0]), 32'h01010101);
      end
      if (v == 3) chk_wide("presync_ff/lb_all_ones", 2048'(lbselect), 2048'({80{1'b1}}));
    end

    for (int k = 0; k < NB; k++) pay[k] = 8'h00;
    run_frame("gap_zero", 100, 8'h00, 1'b1);
    chk("gap_zero/left_zero", 32'(leftioselect), 32'h0);

    for (int k = 0; k < NB; k++) pay[k] = 8'h01;
    pay[5] = 8'hA5;
    run_frame("sync_in_payload", -1, 8'h01, 1'b1);
    chk("sync_in_payload/byte5", 32'(brbselect[47:40]), 32'hA5);

    send_byte(8'hA5);
    for (int k = 0; k < 50; k++) send_byte(8'h3C);
    chk("midreset/busy_before", 32'(busy), 32'd1);
    do_reset();
    chk_reset_state("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
